// File: rtl/wb_arbiter_rr_pkg.sv
// wb_arb_pkg: shared types and helpers for the round-robin Wishbone arbiter.
//   arb_state_e : arbiter FSM state (idle / grant held)
//   rr_pick     : round-robin search, first requester after 'last' with wrap
package wb_arb_pkg;

    typedef enum logic {
        StIdle,
        StGrant
    } arb_state_e;

    // Search req[last+1], req[last+2], ... modulo numm and return the first set index.
    // Returns 'last' unchanged when nothing is requesting. numm must be 1..16.
    function automatic logic [3:0] rr_pick(input logic [15:0] req, input logic [3:0] last,
                                           input int unsigned numm);
        logic [3:0]  pick;
        int unsigned idx;
        pick = last;
        // Walk from the farthest candidate back to the nearest so the nearest wins.
        for (int unsigned k = 16; k >= 1; k--) begin
            if (k <= numm) begin
                idx = (32'(last) + k) % numm;
                if (req[idx[3:0]]) begin
                    pick = idx[3:0];
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/wb_arbiter_rr_if.sv
// wb_arbiter_rr_if: shared-bus arbitration signals between the interconnect and the arbiter.
//   req, stb_i, stall_i, ack_i, err_i          : from interconnect (CYCs, muxed STB, OR'd resp)
//   gnt, gnt_idx, busy                         : registered grant state
//   stall_o, ack_o, err_o, tout, outstanding   : returned to the granted master / status
// Modport 'slave' is the arbiter's view, 'master' the interconnect's view.
interface wb_arbiter_rr_if #(
    parameter int unsigned NUMM    = 2,
    parameter int unsigned MAX_OUT = 4
);
    localparam int unsigned IDX_W = (NUMM > 1) ? $clog2(NUMM) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

    logic [NUMM-1:0]  req;
    logic             stb_i;
    logic             stall_i;
    logic             ack_i;
    logic             err_i;
    logic [NUMM-1:0]  gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             busy;
    logic             stall_o;
    logic             ack_o;
    logic             err_o;
    logic             tout;
    logic [CNT_W-1:0] outstanding;

    modport master (
        output req, stb_i, stall_i, ack_i, err_i,
        input  gnt, gnt_idx, busy, stall_o, ack_o, err_o, tout, outstanding
    );

    modport slave (
        input  req, stb_i, stall_i, ack_i, err_i,
        output gnt, gnt_idx, busy, stall_o, ack_o, err_o, tout, outstanding
    );

endinterface

// File: rtl/wb_arbiter_rr_watchdog.sv
// wb_arb_watchdog: response timeout for the granted master.
//   clk, rst_n : clock, async active-low reset
//   i_cnt_en   : outstanding work and no response this cycle
//   i_clear    : restart the timer (response, first accept, release, idle)
//   o_tout     : one-cycle pulse on the TIMEOUT-th waiting cycle (TIMEOUT=0 disables)
module wb_arb_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_cnt_en,
    input  logic i_clear,
    output logic o_tout
);
    localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TMR_W-1:0] r_timer;
    logic [TMR_W-1:0] w_timer_nxt;
    logic             w_enabled;

    assign w_enabled = (TIMEOUT != 0);
    // The timer holds the number of waiting cycles already completed, so the
    // pulse lands on the TIMEOUT-th one.
    assign o_tout = w_enabled & i_cnt_en & (r_timer == TMR_W'(TIMEOUT - 1));

    always_comb begin
        w_timer_nxt = r_timer;
        if (i_clear || o_tout || !w_enabled) begin
            w_timer_nxt = '0;
        end else if (i_cnt_en) begin
            w_timer_nxt = r_timer + TMR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
        end else begin
            r_timer <= w_timer_nxt;
        end
    end

endmodule

// File: rtl/wb_arbiter_rr.sv
// wb_arbiter_rr: registered round-robin grant and transaction sequencer for a shared
// Wishbone B4 pipelined bus.
//   clk, rst_n : clock, async active-low reset
//   bus        : wb_arbiter_rr_if.slave (requests/responses in, grant/throttle out)
// The grant is held for the whole CYC of the winner; the outstanding count throttles
// the master at MAX_OUT and a watchdog turns a hung transfer into an error.
module wb_arbiter_rr
    import wb_arb_pkg::*;
#(
    parameter int unsigned NUMM    = 2,
    parameter int unsigned MAX_OUT = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst_n,
    wb_arbiter_rr_if.slave bus
);
    localparam int unsigned IDX_W = (NUMM > 1) ? $clog2(NUMM) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

    arb_state_e       r_state, w_state_nxt;
    logic [NUMM-1:0]  r_gnt, w_gnt_nxt;
    logic [IDX_W-1:0] r_gnt_idx, w_gnt_idx_nxt;
    logic [IDX_W-1:0] r_last, w_last_nxt;
    logic             r_busy, w_busy_nxt;
    logic [CNT_W-1:0] r_out, w_out_nxt;

    logic [IDX_W-1:0] w_pick;
    logic             w_granted, w_release, w_out_zero, w_out_full;
    logic             w_stall, w_accept, w_resp, w_dec, w_tout;
    logic             w_wd_cnt_en, w_wd_clear;

    assign w_granted  = (r_state == StGrant);
    assign w_release  = w_granted & ~bus.req[r_gnt_idx];
    assign w_out_zero = (r_out == '0);
    assign w_out_full = (r_out == CNT_W'(MAX_OUT));
    assign w_stall    = ~w_granted | bus.stall_i | w_out_full;
    assign w_accept   = w_granted & bus.stb_i & ~w_stall;
    assign w_resp     = bus.ack_i | bus.err_i;
    // A response with nothing outstanding is spurious: not counted, not forwarded.
    assign w_dec      = (w_resp & ~w_out_zero) | w_tout;
    assign w_pick     = IDX_W'(rr_pick(16'(bus.req), 4'(r_last), NUMM));

    assign w_wd_cnt_en = w_granted & ~w_out_zero & ~w_resp;
    assign w_wd_clear  = w_resp | (w_accept & w_out_zero) | w_release | ~w_granted;

    wb_arb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_cnt_en(w_wd_cnt_en),
        .i_clear (w_wd_clear),
        .o_tout  (w_tout)
    );

    assign bus.gnt         = r_gnt;
    assign bus.gnt_idx     = r_gnt_idx;
    assign bus.busy        = r_busy;
    assign bus.stall_o     = w_stall;
    assign bus.ack_o       = bus.ack_i & r_busy & ~w_out_zero;
    assign bus.err_o       = ((bus.err_i & ~w_out_zero) | w_tout) & r_busy;
    assign bus.tout        = w_tout;
    assign bus.outstanding = r_out;

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_gnt_idx_nxt = r_gnt_idx;
        w_last_nxt    = r_last;
        w_busy_nxt    = r_busy;
        w_out_nxt     = r_out;
        unique case (r_state)
            StIdle: begin
                if (|bus.req) begin
                    w_state_nxt   = StGrant;
                    w_gnt_nxt     = NUMM'(1) << w_pick;
                    w_gnt_idx_nxt = w_pick;
                    w_last_nxt    = w_pick;
                    w_busy_nxt    = 1'b1;
                    w_out_nxt     = '0;
                end
            end
            StGrant: begin
                if (w_release) begin
                    // No re-arbitration here: guarantees an idle cycle between grants.
                    w_state_nxt = StIdle;
                    w_gnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                    w_out_nxt   = '0;
                end else begin
                    w_out_nxt = r_out + CNT_W'(w_accept) - CNT_W'(w_dec);
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_gnt     <= '0;
            r_gnt_idx <= '0;
            r_last    <= IDX_W'(NUMM - 1);
            r_busy    <= 1'b0;
            r_out     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_gnt_idx <= w_gnt_idx_nxt;
            r_last    <= w_last_nxt;
            r_busy    <= w_busy_nxt;
            r_out     <= w_out_nxt;
        end
    end

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(r_gnt));
    a_out_max: assert property (@(posedge clk) disable iff (!rst_n) r_out <= CNT_W'(MAX_OUT));
    a_busy_gnt: assert property (@(posedge clk) disable iff (!rst_n) r_busy == (|r_gnt));
    a_spurious: assert property (@(posedge clk) disable iff (!rst_n)
        (w_out_zero && w_resp) |-> !bus.ack_o);

endmodule

// File: tb/tb_wb_arbiter_rr.sv
module tb_wb_arbiter_rr;
    localparam int N  = 3;
    localparam int MO = 4;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    wb_arbiter_rr_if #(.NUMM(N), .MAX_OUT(MO)) bus ();

    wb_arbiter_rr #(
        .NUMM   (N),
        .MAX_OUT(MO),
        .TIMEOUT(TO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0] req;
        logic       stb, stall, ack, err;
        logic [2:0] gnt;
        logic       busy, stall_o, ack_o, err_o;
        int         out;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] rq, input logic s, input logic st,
                                input logic a, input logic e, input logic [2:0] g,
                                input logic b, input logic so, input logic ao,
                                input logic eo, input int o);
        vec_t v;
        v.req = rq; v.stb = s; v.stall = st; v.ack = a; v.err = e;
        v.gnt = g; v.busy = b; v.stall_o = so; v.ack_o = ao; v.err_o = eo; v.out = o;
        return v;
    endfunction

    // Behavioural reference: who owns the bus, how many requests await an answer,
    // and how long the oldest wait has gone unanswered.
    int m_busy, m_idx, m_last, m_out, m_quiet;

    task automatic model_reset();
        m_busy = 0; m_idx = 0; m_last = N - 1; m_out = 0; m_quiet = 0;
    endtask

    task automatic model_eval(input logic [2:0] rq, input logic s, input logic st,
                              input logic a, input logic e, output logic [2:0] g,
                              output logic b, output logic so, output logic ao,
                              output logic eo, output logic tt, output int o);
        logic acc, rsp;
        so  = (m_busy == 0) || st || (m_out == MO);
        acc = (m_busy != 0) && s && !so;
        rsp = a || e;
        tt  = (m_busy != 0) && (m_out > 0) && !rsp && (m_quiet == TO - 1);
        ao  = a && (m_busy != 0) && (m_out > 0);
        eo  = (m_busy != 0) && ((e && m_out > 0) || tt);
        g   = (m_busy != 0) ? 3'(1 << m_idx) : 3'b000;
        b   = (m_busy != 0);
        o   = m_out;
        // advance to the state after the coming edge
        if (m_busy == 0) begin
            if (rq != 3'b000) begin
                for (int k = 1; k <= N; k++) begin
                    if (rq[(m_last + k) % N]) begin
                        m_idx = (m_last + k) % N;
                        break;
                    end
                end
                m_busy = 1; m_last = m_idx; m_out = 0; m_quiet = 0;
            end
        end else if (!rq[m_idx]) begin
            m_busy = 0; m_out = 0; m_quiet = 0;
        end else begin
            int old;
            old = m_out;
            if (acc) m_out++;
            if ((rsp && old > 0) || tt) m_out--;
            if (rsp || tt || (acc && old == 0)) m_quiet = 0;
            else if (old > 0) m_quiet++;
        end
    endtask

    task automatic drive(input logic [2:0] rq, input logic s, input logic st,
                         input logic a, input logic e);
        bus.req = rq; bus.stb_i = s; bus.stall_i = st; bus.ack_i = a; bus.err_i = e;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        vec_t vecs[$];
        int   n_tout, t_at, err_cycles, err_at_tout, out8, out9, found;
        int   order[4] = '{0, 1, 2, 0};
        logic [2:0] req_v;

        rst_n = 1'b0;
        drive(3'b000, 0, 0, 0, 0);
        repeat (2) step();
        rst_n = 1'b1;

        @(negedge clk);
        chk("reset.gnt", int'(bus.gnt), 0);
        chk("reset.busy", int'(bus.busy), 0);
        chk("reset.stall_o", int'(bus.stall_o), 1);
        chk("reset.out", int'(bus.outstanding), 0);
        chk("reset.tout", int'(bus.tout), 0);
        step();

        //                   req    stb st ack err  gnt   busy so ao eo out
        vecs.push_back(mk(3'b011, 0, 0, 0, 0, 3'b000, 0, 1, 0, 0, 0));
        vecs.push_back(mk(3'b011, 0, 0, 0, 0, 3'b001, 1, 0, 0, 0, 0));
        vecs.push_back(mk(3'b010, 0, 0, 0, 0, 3'b001, 1, 0, 0, 0, 0));
        vecs.push_back(mk(3'b010, 0, 0, 0, 0, 3'b000, 0, 1, 0, 0, 0));
        vecs.push_back(mk(3'b010, 0, 0, 0, 0, 3'b010, 1, 0, 0, 0, 0));
        vecs.push_back(mk(3'b010, 1, 0, 0, 0, 3'b010, 1, 0, 0, 0, 0));
        vecs.push_back(mk(3'b010, 1, 0, 0, 0, 3'b010, 1, 0, 0, 0, 1));
        vecs.push_back(mk(3'b010, 1, 0, 0, 0, 3'b010, 1, 0, 0, 0, 2));
        vecs.push_back(mk(3'b010, 1, 0, 0, 0, 3'b010, 1, 0, 0, 0, 3));
        vecs.push_back(mk(3'b010, 1, 0, 0, 0, 3'b010, 1, 1, 0, 0, 4));
        vecs.push_back(mk(3'b010, 0, 0, 1, 0, 3'b010, 1, 1, 1, 0, 4));
        vecs.push_back(mk(3'b010, 0, 1, 0, 0, 3'b010, 1, 1, 0, 0, 3));
        vecs.push_back(mk(3'b010, 0, 0, 0, 0, 3'b010, 1, 0, 0, 0, 3));
        vecs.push_back(mk(3'b010, 0, 0, 1, 0, 3'b010, 1, 0, 1, 0, 3));
        vecs.push_back(mk(3'b010, 1, 0, 1, 0, 3'b010, 1, 0, 1, 0, 2));
        vecs.push_back(mk(3'b010, 0, 0, 0, 1, 3'b010, 1, 0, 0, 1, 2));
        vecs.push_back(mk(3'b000, 0, 0, 0, 0, 3'b010, 1, 0, 0, 0, 1));
        vecs.push_back(mk(3'b000, 0, 0, 0, 0, 3'b000, 0, 1, 0, 0, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].req, vecs[i].stb, vecs[i].stall, vecs[i].ack, vecs[i].err);
            @(negedge clk);
            chk($sformatf("vec%0d.gnt", i), int'(bus.gnt), int'(vecs[i].gnt));
            chk($sformatf("vec%0d.busy", i), int'(bus.busy), int'(vecs[i].busy));
            chk($sformatf("vec%0d.stall_o", i), int'(bus.stall_o), int'(vecs[i].stall_o));
            chk($sformatf("vec%0d.ack_o", i), int'(bus.ack_o), int'(vecs[i].ack_o));
            chk($sformatf("vec%0d.err_o", i), int'(bus.err_o), int'(vecs[i].err_o));
            chk($sformatf("vec%0d.out", i), int'(bus.outstanding), vecs[i].out);
            step();
        end

        // Timeout: one accept, no response.
        drive(3'b001, 0, 0, 0, 0);
        @(negedge clk);
        chk("tout.idle_before", int'(bus.busy), 0);
        step();
        @(negedge clk);
        chk("tout.gnt", int'(bus.gnt), 1);
        step();
        bus.stb_i = 1'b1;
        step();
        bus.stb_i = 1'b0;
        n_tout = 0; t_at = -1; err_cycles = 0; err_at_tout = 0; out8 = -1; out9 = -1;
        for (int k = 1; k <= 11; k++) begin
            @(negedge clk);
            if (bus.err_o) err_cycles++;
            if (bus.tout) begin
                n_tout++;
                t_at = k;
                err_at_tout = int'(bus.err_o);
            end
            if (k == 8) out8 = int'(bus.outstanding);
            if (k == 9) out9 = int'(bus.outstanding);
            step();
        end
        chk("tout.pulses", n_tout, 1);
        chk("tout.cycle", t_at, 8);
        chk("tout.err_with_tout", err_at_tout, 1);
        chk("tout.err_cycles", err_cycles, 1);
        chk("tout.out_before", out8, 1);
        chk("tout.out_after", out9, 0);
        bus.ack_i = 1'b1;
        @(negedge clk);
        chk("tout.late_ack_o", int'(bus.ack_o), 0);
        chk("tout.late_out", int'(bus.outstanding), 0);
        step();
        bus.ack_i = 1'b0;
        @(negedge clk);
        chk("tout.late_out2", int'(bus.outstanding), 0);
        step();

        // Asynchronous reset mid-grant with three outstanding.
        bus.stb_i = 1'b1;
        repeat (3) step();
        bus.stb_i = 1'b0;
        @(negedge clk);
        chk("arst.out_before", int'(bus.outstanding), 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.gnt", int'(bus.gnt), 0);
        chk("arst.out", int'(bus.outstanding), 0);
        chk("arst.stall_o", int'(bus.stall_o), 1);
        chk("arst.busy", int'(bus.busy), 0);
        step();
        rst_n = 1'b1;

        // Rotation: all three request, each does one transfer then drops CYC one cycle.
        drive(3'b111, 0, 0, 0, 0);
        for (int g = 0; g < 4; g++) begin
            found = 0;
            for (int w = 0; w < 10; w++) begin
                @(negedge clk);
                if (bus.busy) begin
                    found = 1;
                    break;
                end
                step();
            end
            chk($sformatf("rot%0d.found", g), found, 1);
            if (found == 0) break;
            chk($sformatf("rot%0d.idx", g), int'(bus.gnt_idx), order[g]);
            bus.stb_i = 1'b1;
            step();
            bus.stb_i = 1'b0;
            bus.ack_i = 1'b1;
            @(negedge clk);
            chk($sformatf("rot%0d.ack_o", g), int'(bus.ack_o), 1);
            step();
            bus.ack_i = 1'b0;
            req_v = 3'b111;
            req_v[bus.gnt_idx] = 1'b0;
            bus.req = req_v;
            step();
            bus.req = 3'b111;
        end

        // Randomized run against the reference model.
        rst_n = 1'b0;
        drive(3'b000, 0, 0, 0, 0);
        step();
        rst_n = 1'b1;
        model_reset();
        req_v = 3'b000;
        for (int c = 0; c < 3000; c++) begin
            logic [2:0] e_g;
            logic       e_b, e_so, e_ao, e_eo, e_t, quiet_phase;
            int         e_o;
            logic       s, st, a, e;
            quiet_phase = ((c / 150) % 2) == 1;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 15) == 0) req_v[i] = ~req_v[i];
            end
            s  = ($urandom_range(0, 1) == 1);
            st = ($urandom_range(0, 3) == 0);
            a  = quiet_phase ? ($urandom_range(0, 31) == 0) : ($urandom_range(0, 2) == 0);
            e  = ($urandom_range(0, 19) == 0);
            drive(req_v, s, st, a, e);
            @(negedge clk);
            model_eval(req_v, s, st, a, e, e_g, e_b, e_so, e_ao, e_eo, e_t, e_o);
            chk($sformatf("rnd%0d.outputs", c),
                int'({bus.gnt, bus.busy, bus.stall_o, bus.ack_o, bus.err_o, bus.tout,
                      3'(bus.outstanding)}),
                int'({e_g, e_b, e_so, e_ao, e_eo, e_t, 3'(e_o)}));
            if (e_b) chk($sformatf("rnd%0d.gnt_idx", c), int'(bus.gnt_idx), m_last);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
